// File: rtl/pulse_train_gen.sv
// Programmable square-wave pulse train: H cycles high, L cycles low, N rising edges or free-running until stop.
// Latency: accepted start -> signal=1 on the next cycle; all outputs registered, no input-to-output paths.
// Backpressure: none; start is ignored while busy, stop is held pending and honoured at the end of the current LOW.
module pulse_train_gen #(
    parameter int WIDTH       = 12,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [WIDTH-1:0]       high_cycles,
    input  logic [WIDTH-1:0]       low_cycles,
    input  logic [COUNT_WIDTH-1:0] num_edges,
    output logic                   signal,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] edges_sent
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]       PH_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0] EDGE_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       h_q, h_d;
    logic [WIDTH-1:0]       l_q, l_d;
    logic [COUNT_WIDTH-1:0] n_q, n_d;
    logic                   stop_q, stop_d;
    logic                   signal_d, busy_d, done_d;
    logic [COUNT_WIDTH-1:0] edges_d;

    logic [WIDTH-1:0]       h_clamp, l_clamp;
    logic                   last_edge;

    // A zero phase length behaves as one cycle so the counter never underflows.
    assign h_clamp   = (high_cycles == '0) ? PH_ONE : high_cycles;
    assign l_clamp   = (low_cycles  == '0) ? PH_ONE : low_cycles;
    assign last_edge = (n_q != '0) && (edges_sent == n_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        h_d      = h_q;
        l_d      = l_q;
        n_d      = n_q;
        stop_d   = stop_q;
        signal_d = signal;
        busy_d   = busy;
        done_d   = 1'b0;
        edges_d  = edges_sent;

        case (state_q)
            IDLE: begin
                if (start) begin
                    h_d      = h_clamp;
                    l_d      = l_clamp;
                    n_d      = num_edges;
                    stop_d   = 1'b0;
                    cnt_d    = h_clamp - PH_ONE;
                    state_d  = HIGH;
                    signal_d = 1'b1;
                    busy_d   = 1'b1;
                    edges_d  = EDGE_ONE;
                end
            end

            HIGH: begin
                if (stop) begin
                    stop_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d  = LOW;
                    cnt_d    = l_q - PH_ONE;
                    signal_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - PH_ONE;
                end
            end

            LOW: begin
                if (stop) begin
                    stop_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    // Termination uses only the registered request, so a stop seen on the
                    // final LOW cycle still lets one more period go out.
                    if (last_edge || stop_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        stop_d  = 1'b0;
                    end else begin
                        state_d  = HIGH;
                        cnt_d    = h_q - PH_ONE;
                        signal_d = 1'b1;
                        edges_d  = edges_sent + EDGE_ONE;
                    end
                end else begin
                    cnt_d = cnt_q - PH_ONE;
                end
            end

            default: begin
                state_d  = IDLE;
                signal_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            h_q        <= '0;
            l_q        <= '0;
            n_q        <= '0;
            stop_q     <= 1'b0;
            signal     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            edges_sent <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            h_q        <= h_d;
            l_q        <= l_d;
            n_q        <= n_d;
            stop_q     <= stop_d;
            signal     <= signal_d;
            busy       <= busy_d;
            done       <= done_d;
            edges_sent <= edges_d;
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: stimulus pushes expected rise/done events, a monitor pops them.
// Includes a registered rising-edge detector on signal for the loopback case.
module tb_pulse_train_gen;

    localparam int W  = 12;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          stop;
    logic [W-1:0]  high_cycles;
    logic [W-1:0]  low_cycles;
    logic [CW-1:0] num_edges;
    logic          signal;
    logic          busy;
    logic          done;
    logic [CW-1:0] edges_sent;

    pulse_train_gen #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .high_cycles(high_cycles),
        .low_cycles (low_cycles),
        .num_edges  (num_edges),
        .signal     (signal),
        .busy       (busy),
        .done       (done),
        .edges_sent (edges_sent)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Rising-edge detector: pulse appears two cycles after signal rises.
    logic s1 = 1'b0, s2 = 1'b0, det = 1'b0;
    always @(posedge clk) begin
        s1  <= signal;
        s2  <= s1;
        det <= s1 & ~s2;
    end

    typedef struct {
        bit is_done;
        int cyc;
        int edges;
    } ev_t;

    ev_t  exp_q[$];
    int   det_q[$];
    ev_t  mon_e;
    int   mon_d;
    bit   prev_sig = 1'b0;
    bit   det_en   = 1'b0;
    int   det_cnt  = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   t0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_ev(input bit is_done, input int c, input int e);
        ev_t x;
        x.is_done = is_done;
        x.cyc     = c;
        x.edges   = e;
        exp_q.push_back(x);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Presents a start on the next negedge; returns the cycle index that counts as cycle 0.
    task automatic arm(input int h, input int l, input int n, output int t);
        @(negedge clk);
        high_cycles = W'(h);
        low_cycles  = W'(l);
        num_edges   = CW'(n);
        start       = 1'b1;
        t           = cyc;
    endtask

    task automatic release_start;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic handle_event(input bit is_done, input string tag);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s actual=cycle %0d edges %0d required=no event", tag, cyc, edges_sent);
        end else begin
            mon_e = exp_q.pop_front();
            chk({tag, "_kind"}, int'(is_done), int'(mon_e.is_done));
            chk({tag, "_cycle"}, cyc, mon_e.cyc);
            chk({tag, "_edges"}, int'(edges_sent), mon_e.edges);
        end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        high_cycles = '0;
        low_cycles  = '0;
        num_edges   = '0;

        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (signal && !prev_sig) handle_event(1'b0, "rise");
                    if (done) handle_event(1'b1, "done");
                    if (det && det_en) begin
                        det_cnt++;
                        if (det_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_det actual=cycle %0d required=no pulse", cyc);
                        end else begin
                            mon_d = det_q.pop_front();
                            chk("det_cycle", cyc, mon_d);
                        end
                    end
                    prev_sig = signal;
                end
            end

            begin : stimulus
                repeat (3) @(negedge clk);
                chk("rst_signal", int'(signal), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_edges", int'(edges_sent), 0);
                reset = 1'b0;
                repeat (2) @(negedge clk);

                // Counted train H=2 L=3 N=3.
                arm(2, 3, 3, t0);
                push_ev(0, t0 + 1, 1);
                push_ev(0, t0 + 6, 2);
                push_ev(0, t0 + 11, 3);
                push_ev(1, t0 + 16, 3);
                release_start;
                wait_cyc(t0 + 2);
                chk("t1_sig_c2", int'(signal), 1);
                wait_cyc(t0 + 3);
                chk("t1_sig_c3", int'(signal), 0);
                wait_cyc(t0 + 15);
                chk("t1_busy_c15", int'(busy), 1);
                wait_cyc(t0 + 16);
                chk("t1_busy_c16", int'(busy), 0);
                wait_cyc(t0 + 22);
                chk("t1_edges_after", int'(edges_sent), 3);
                chk("t1_queue_empty", exp_q.size(), 0);

                // Clamped zero lengths, minimum period.
                arm(0, 0, 4, t0);
                push_ev(0, t0 + 1, 1);
                push_ev(0, t0 + 3, 2);
                push_ev(0, t0 + 5, 3);
                push_ev(0, t0 + 7, 4);
                push_ev(1, t0 + 9, 4);
                release_start;
                for (int k = 1; k <= 8; k++) begin
                    wait_cyc(t0 + k);
                    chk($sformatf("t2_sig_c%0d", k), int'(signal), k % 2);
                end
                wait_cyc(t0 + 12);
                chk("t2_edges_after", int'(edges_sent), 4);
                chk("t2_queue_empty", exp_q.size(), 0);

                // Continuous with stop at cycle 6.
                arm(1, 1, 0, t0);
                push_ev(0, t0 + 1, 1);
                push_ev(0, t0 + 3, 2);
                push_ev(0, t0 + 5, 3);
                push_ev(0, t0 + 7, 4);
                push_ev(1, t0 + 9, 4);
                release_start;
                wait_cyc(t0 + 6);
                stop = 1'b1;
                @(negedge clk);
                stop = 1'b0;
                wait_cyc(t0 + 14);
                chk("t3_edges_after", int'(edges_sent), 4);
                chk("t3_busy_after", int'(busy), 0);
                chk("t3_queue_empty", exp_q.size(), 0);

                // Ignored start while busy, then back-to-back start on done.
                arm(1, 2, 2, t0);
                push_ev(0, t0 + 1, 1);
                push_ev(0, t0 + 4, 2);
                push_ev(1, t0 + 7, 2);
                push_ev(0, t0 + 8, 1);
                push_ev(0, t0 + 11, 2);
                push_ev(1, t0 + 14, 2);
                release_start;
                wait_cyc(t0 + 3);
                num_edges = CW'(9);
                start     = 1'b1;
                @(negedge clk);
                start     = 1'b0;
                num_edges = CW'(2);
                wait_cyc(t0 + 7);
                chk("t4_done_c7", int'(done), 1);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("t4_sig_c8", int'(signal), 1);
                chk("t4_edges_c8", int'(edges_sent), 1);
                wait_cyc(t0 + 18);
                chk("t4_edges_after", int'(edges_sent), 2);
                chk("t4_queue_empty", exp_q.size(), 0);

                // Reset mid-train, then a normal train.
                arm(4, 4, 5, t0);
                push_ev(0, t0 + 1, 1);
                push_ev(0, t0 + 9, 2);
                release_start;
                wait_cyc(t0 + 10);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk("t5_sig_c11", int'(signal), 0);
                chk("t5_busy_c11", int'(busy), 0);
                chk("t5_edges_c11", int'(edges_sent), 0);
                chk("t5_done_c11", int'(done), 0);
                wait_cyc(t0 + 60);
                chk("t5_queue_empty", exp_q.size(), 0);
                arm(2, 2, 2, t0);
                push_ev(0, t0 + 1, 1);
                push_ev(0, t0 + 5, 2);
                push_ev(1, t0 + 9, 2);
                release_start;
                wait_cyc(t0 + 14);
                chk("t5b_edges_after", int'(edges_sent), 2);
                chk("t5b_queue_empty", exp_q.size(), 0);

                // Loopback through the edge detector, H=3 L=5 N=10.
                det_en  = 1'b1;
                det_cnt = 0;
                arm(3, 5, 10, t0);
                for (int k = 1; k <= 10; k++) begin
                    push_ev(0, t0 + 1 + (k - 1) * 8, k);
                    det_q.push_back(t0 + 3 + (k - 1) * 8);
                end
                push_ev(1, t0 + 81, 10);
                release_start;
                wait_cyc(t0 + 92);
                chk("t6_det_count", det_cnt, 10);
                chk("t6_edges_after", int'(edges_sent), det_cnt);
                chk("t6_edges_value", int'(edges_sent), 10);
                chk("t6_queue_empty", exp_q.size(), 0);
                chk("t6_detq_empty", det_q.size(), 0);
            end

            begin : watchdog
                repeat (20000) @(posedge clk);
                errors++;
                $display("FAIL watchdog actual=timeout required=bench completion");
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "watchdog expired");
            end
        join_any

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
